code_entry_ctrl: RTL
====================

# code_entry_ctrl

Passcode-entry controller that sequences the eight-digit seven-segment display controller in the security device. It accepts single-cycle keypad strobes, buffers up to four entered digits, compares them against the stored code, and runs the entry / check / open / lockout sequence. Its registered outputs drive the display's digit value, banner mode and per-digit valid mask. It also drives the `unlock` and `alarm` outputs toward the lock hardware.

## Interface
- `OPEN_CYCLES`, default 100_000_000: number of cycles `unlock` is held after a correct code.
- `LOCKOUT_CYCLES`, default 500_000_000: number of cycles keys are ignored after too many failures.
- `MAX_FAIL`, default 3: consecutive wrong codes that trigger a lockout. Legal range 1..7.
- `RESET_CODE`, default 16'h1234: stored code after reset, four BCD nibbles, [15:12] is the first digit.
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `key_valid` input 1: one-cycle strobe; `key_code` is sampled when this is high.
- `key_code` input 4: 0x0–0x9 are digits, 0xC is CLEAR, 0xE is ENTER; every other value is ignored.
- `digits` output 16: four BCD nibbles for the display. [3:0] is the newest digit.
- `disp_mode` output 2: banner select. 2'b00 = OPEN, 2'b01 = LOCKED/entry, 2'b10 = ALARM, 2'b11 = blank.
- `valid` output 4: per-nibble enable for `digits`. Bit i is set when nibble i holds an entered digit.
- `unlock` output 1: high while in the OPEN state.
- `alarm` output 1: high while in the LOCKOUT state.

## Operation
- States and their outputs:
  - ENTRY: `disp_mode` = 01, keys accepted.
  - CHECK: one cycle long, keys dropped.
  - OPEN: `disp_mode` = 00, `unlock` = 1.
  - LOCKOUT: `disp_mode` = 10, `alarm` = 1, `valid` = 0, all keys dropped.
- Reset values: state ENTRY, `digits` = 0, `valid` = 0, `disp_mode` = 01, `unlock` = 0, `alarm` = 0, fail counter 0, stored code `RESET_CODE`, timer 0.
- Digit key in ENTRY:
  - If `valid` != 4'hF: `digits` <= {`digits`[11:0], key}; `valid` <= {`valid`[2:0], 1}.
  - If `valid` == 4'hF (buffer full): the key is ignored and the buffer is unchanged.
- CLEAR in ENTRY: `digits` <= 0, `valid` <= 0.
- ENTER in ENTRY:
  - With `valid` == 4'hF: go to CHECK.
  - With fewer than four digits: ignored, not counted as a failure.
- CHECK compares `digits` against the stored code. The buffer is cleared on exit in every case.
  - Match: fail counter cleared, go to OPEN, timer loaded with `OPEN_CYCLES`-1.
  - Mismatch with fail+1 < `MAX_FAIL`: fail counter incremented, go back to ENTRY.
  - Mismatch with fail+1 == `MAX_FAIL`: fail counter cleared, go to LOCKOUT, timer loaded with `LOCKOUT_CYCLES`-1.
- OPEN:
  - Timer reaching 0 returns the block to ENTRY.
  - CLEAR relocks immediately: next state is ENTRY.
- LOCKOUT: timer reaching 0 returns the block to ENTRY.
- Simultaneous events: timer expiry and `key_valid` in the same cycle means the expiry wins and the key is dropped.
- Reset asserted in any state, including mid-entry or mid-timer, returns all state to the reset values on the next edge.

## Timing
- All outputs are registered. A key accepted at edge t is visible on `digits`/`valid` after edge t.
- ENTER accepted at edge t: CHECK during cycle t+1; the OPEN, ENTRY or LOCKOUT outputs are visible from edge t+2.
- `unlock` stays high for exactly `OPEN_CYCLES` cycles unless CLEAR arrives. `alarm` stays high for exactly `LOCKOUT_CYCLES` cycles.
- Timer width is $clog2(max(`OPEN_CYCLES`, `LOCKOUT_CYCLES`)). It is a down-counter that never wraps.
- Back-to-back `key_valid` pulses on consecutive cycles are each processed.

## Configuration
- `CODE_CHANGE_EN` defined:
  - In OPEN, digit keys fill the buffer exactly as in ENTRY, and `valid`/`digits` are shown under the OPEN banner.
  - ENTER with four digits stores the buffer as the new code, clears the buffer, drops `unlock` and goes to ENTRY on the next edge.
  - CLEAR with a non-empty buffer clears the buffer only; CLEAR with an empty buffer relocks.
- `CODE_CHANGE_EN` undefined:
  - Digit keys and ENTER are ignored in OPEN, and CLEAR relocks.
  - The stored code is the constant `RESET_CODE`, with no code register.

## Structure
- Shared package `security_pkg` holds:
  - the state enum (ENTRY, CHECK, OPEN, LOCKOUT);
  - the key-code constants KEY_CLEAR = 4'hC and KEY_ENTER = 4'hE;
  - the disp_mode constants MODE_OPEN, MODE_LOCKED, MODE_ALARM, MODE_BLANK.
- Sub-module `cycle_timer` is a loadable down-counter with a `load`, `value` and `zero` interface, parameterized by width. One instance serves both OPEN and LOCKOUT.

## Test plan
- Reset, then keys 1,2,3,4 and ENTER → `valid` steps 1,3,7,F with `digits` = 16'h1234; at t+2 `unlock` = 1 and `disp_mode` = 00; `unlock` drops after `OPEN_CYCLES` (8 in the bench) cycles.
- Keys 1,2,3,5,6 → fifth key ignored, `digits` = 16'h1235. ENTER → back to ENTRY with `valid` = 0 and `unlock` = 0.
- Three wrong codes with `MAX_FAIL` = 3 → after the third, `alarm` = 1, `disp_mode` = 10 and keys are ignored for `LOCKOUT_CYCLES` (16 in the bench), then ENTRY. A correct code afterwards opens.
- ENTER after two digits → no state change and no failure counted. CLEAR → `valid` = 0.
- Timer expiry coincident with a digit key in OPEN → ENTRY is entered and `valid` stays 0.
- With `CODE_CHANGE_EN`: open, enter 9,8,7,6 and ENTER → the code is changed; 1,2,3,4 then fails and 9,8,7,6 opens. Reset mid-OPEN → `unlock` = 0 next edge and the code reverts to 16'h1234.

Source files
------------

// File: rtl/security_pkg.sv
// Shared types and constants for the security device front panel.
package security_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BUF_W   = 16;
    localparam int unsigned FAIL_W  = 3;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hC;
    localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hE;

    localparam logic [1:0] MODE_OPEN   = 2'b00;
    localparam logic [1:0] MODE_LOCKED = 2'b01;
    localparam logic [1:0] MODE_ALARM  = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    // Banner shown for each controller state.
    function automatic logic [1:0] mode_of(state_t s);
        case (s)
            ST_OPEN:    return MODE_OPEN;
            ST_LOCKOUT: return MODE_ALARM;
            default:    return MODE_LOCKED;
        endcase
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; zero flag is registered.
module cycle_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= value;
            zero  <= (value == '0);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
            zero  <= (count == WIDTH'(1));
        end
    end

endmodule

// File: rtl/code_entry_ctrl.sv
// Passcode entry / check / open / lockout sequencer for the display and lock.
// Optional feature: define CODE_CHANGE_EN to allow changing the code while open.
module code_entry_ctrl
    import security_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES    = 100_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [15:0] RESET_CODE     = 16'h1234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [1:0]  disp_mode,
    output logic [3:0]  valid,
    output logic        unlock,
    output logic        alarm
);

    localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    digits_d;
    logic [3:0]          valid_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [BUF_W-1:0]    stored_code;
    logic                tmr_load;
    logic [TW-1:0]       tmr_value;
    logic                tmr_zero;

    logic is_digit, is_clear, is_enter, buf_full, buf_empty, last_fail;

    assign is_digit  = (key_code <= 4'd9);
    assign is_clear  = (key_code == KEY_CLEAR);
    assign is_enter  = (key_code == KEY_ENTER);
    assign buf_full  = (valid == 4'hF);
    assign buf_empty = (valid == 4'h0);
    assign last_fail = ((4'({1'b0, fail_q}) + 4'd1) == 4'(MAX_FAIL));

`ifdef CODE_CHANGE_EN
    logic [BUF_W-1:0] code_q, code_d;
    assign stored_code = code_q;

    // Programmable code register, reverts to the reset code.
    always_ff @(posedge clk) begin
        if (reset) code_q <= RESET_CODE;
        else       code_q <= code_d;
    end
`else
    assign stored_code = RESET_CODE;
`endif

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_ENTRY;
        else       state_q <= state_d;
    end

    // Next state, buffer, fail counter and timer control.
    always_comb begin
        state_d   = state_q;
        digits_d  = digits;
        valid_d   = valid;
        fail_d    = fail_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
`ifdef CODE_CHANGE_EN
        code_d    = code_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (is_digit && !buf_full) begin
                        digits_d = {digits[11:0], key_code};
                        valid_d  = {valid[2:0], 1'b1};
                    end else if (is_clear) begin
                        digits_d = '0;
                        valid_d  = '0;
                    end else if (is_enter && buf_full) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                digits_d = '0;
                valid_d  = '0;
                if (digits == stored_code) begin
                    fail_d    = '0;
                    state_d   = ST_OPEN;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(OPEN_CYCLES - 1);
                end else if (last_fail) begin
                    fail_d    = '0;
                    state_d   = ST_LOCKOUT;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(LOCKOUT_CYCLES - 1);
                end else begin
                    fail_d  = fail_q + FAIL_W'(1);
                    state_d = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (tmr_zero) begin
                    state_d  = ST_ENTRY;
                    digits_d = '0;
                    valid_d  = '0;
                end else if (key_valid) begin
`ifdef CODE_CHANGE_EN
                    if (is_digit && !buf_full) begin
                        digits_d = {digits[11:0], key_code};
                        valid_d  = {valid[2:0], 1'b1};
                    end else if (is_enter && buf_full) begin
                        code_d   = digits;
                        digits_d = '0;
                        valid_d  = '0;
                        state_d  = ST_ENTRY;
                    end else if (is_clear) begin
                        digits_d = '0;
                        valid_d  = '0;
                        if (buf_empty) state_d = ST_ENTRY;
                    end
`else
                    if (is_clear) state_d = ST_ENTRY;
`endif
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) state_d = ST_ENTRY;
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // Registered datapath and state-decoded outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits    <= '0;
            valid     <= '0;
            fail_q    <= '0;
            disp_mode <= MODE_LOCKED;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            digits    <= digits_d;
            valid     <= valid_d;
            fail_q    <= fail_d;
            disp_mode <= mode_of(state_d);
            unlock    <= (state_d == ST_OPEN);
            alarm     <= (state_d == ST_LOCKOUT);
        end
    end

endmodule
